// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer.
package timer_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_t;

endpackage

// File: rtl/dec.sv
// Combinational decrementer, the counterpart of the datapath incrementer.
module dec #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  assign out = in - WIDTH'(1);

endmodule

// File: rtl/down_timer.sv
// Programmable countdown timer: one-shot/periodic, pause/resume, registered tc pulse.
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             cl,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] X,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  output logic [WIDTH-1:0] Y,
  output logic             running,
  output logic             tc
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, q_nxt, q_dec;
  logic [WIDTH-1:0] rld, rld_nxt;
  logic             tc_nxt;
  logic             q_zero, rld_zero;

  dec #(.WIDTH(WIDTH)) u_dec (.in(q), .out(q_dec));

  assign q_zero   = (q == '0);
  assign rld_zero = (rld == '0);

  always_ff @(posedge cl or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      q     <= '0;
      rld   <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      rld   <= rld_nxt;
      tc    <= tc_nxt;
    end
  end

  // Priority: load > stop > start > count. tc defaults low so it is a single-cycle pulse.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    rld_nxt   = rld;
    tc_nxt    = 1'b0;
    if (!load) begin
      rld_nxt   = X;
      q_nxt     = X;
      state_nxt = IDLE;
    end else if (stop) begin
      if (state == RUN) state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (!q_zero) begin
              state_nxt = RUN;
            end else if (!rld_zero) begin
              q_nxt     = rld;
              state_nxt = RUN;
            end else begin
              tc_nxt    = 1'b1;
              state_nxt = EXPIRED;
            end
          end
        end
        EXPIRED: begin
          if (start) begin
            if (!rld_zero) begin
              q_nxt     = rld;
              state_nxt = RUN;
            end else begin
              tc_nxt = 1'b1;
            end
          end
        end
        RUN: begin
          if (q_zero) begin
            // only reachable after a periodic terminal count
            q_nxt = rld;
          end else begin
            q_nxt = q_dec;
            if (q == WIDTH'(1)) begin
              tc_nxt    = 1'b1;
              state_nxt = (periodic && !rld_zero) ? RUN : EXPIRED;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign Y       = q;
  assign running = (state == RUN);

endmodule

// File: tb/tb_down_timer.sv
// Randomized and directed checks of down_timer against a behavioural model.
module tb_down_timer;

  logic        cl = 1'b0;
  logic        clear = 1'b1;
  logic        load = 1'b1;
  logic [31:0] X = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        periodic = 1'b0;
  logic [31:0] Y;
  logic        running;
  logic        tc;

  int checks = 0;
  int errors = 0;

  down_timer #(.WIDTH(32)) dut (
    .cl(cl), .clear(clear), .load(load), .X(X), .start(start), .stop(stop),
    .periodic(periodic), .Y(Y), .running(running), .tc(tc)
  );

  always #5 cl = ~cl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode is "idle", "run" or "expired"
  logic [31:0] m_q, m_r;
  string       m_mode;
  bit          m_tc;

  task automatic model_reset();
    m_q = 0; m_r = 0; m_mode = "idle"; m_tc = 0;
  endtask

  task automatic model_edge();
    logic [31:0] src;
    m_tc = 0;
    if (!load) begin
      m_r = X; m_q = X; m_mode = "idle";
    end else if (stop) begin
      if (m_mode == "run") m_mode = "idle";
    end else if (start && m_mode != "run") begin
      src = (m_mode == "idle" && m_q != 0) ? m_q : m_r;
      if (src != 0) begin
        m_q = src; m_mode = "run";
      end else begin
        m_tc = 1; m_mode = "expired";
      end
    end else if (m_mode == "run") begin
      if (m_q == 0) m_q = m_r;
      else begin
        m_q = m_q - 1;
        if (m_q == 0) begin
          m_tc = 1;
          if (!(periodic && m_r != 0)) m_mode = "expired";
        end
      end
    end
  endtask

  task automatic step();
    @(posedge cl);
    model_edge();
    #1;
    chk("Y", Y, m_q);
    chk("running", running, (m_mode == "run"));
    chk("tc", tc, m_tc);
  endtask

  task automatic cyc(input bit ld_n, input logic [31:0] x, input bit sa, input bit sp);
    load = ld_n; X = x; start = sa; stop = sp;
    step();
    load = 1'b1; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 clear = 1'b0;
    #2;
    chk("rst_Y", Y, 0);
    chk("rst_running", running, 0);
    chk("rst_tc", tc, 0);
    #9 clear = 1'b1;

    // reset mid-count
    cyc(0, 10, 0, 0);
    cyc(1, 0, 1, 0);
    repeat (3) cyc(1, 0, 0, 0);
    chk("pre_clear_Y", Y, 7);
    clear = 1'b0;
    #1;
    model_reset();
    chk("clr_Y", Y, 0);
    chk("clr_running", running, 0);
    chk("clr_tc", tc, 0);
    #1 clear = 1'b1;
    cyc(1, 0, 1, 0);
    chk("clr_start_running", running, 0);
    cyc(0, 4, 0, 0);
    cyc(1, 0, 1, 0);
    chk("clr_reload_Y", Y, 4);

    // one-shot
    periodic = 0;
    cyc(0, 3, 0, 0);
    cyc(1, 0, 1, 0);
    chk("os_Y3", Y, 3);
    for (int i = 2; i >= 0; i--) begin
      cyc(1, 0, 0, 0);
      chk("os_Y", Y, i);
      chk("os_tc", tc, (i == 0));
    end
    cyc(1, 0, 0, 0);
    chk("os_expired", running, 0);

    // periodic
    periodic = 1;
    cyc(0, 2, 0, 0);
    cyc(1, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      chk("per_Y", Y, 2 - (i % 3));
      chk("per_tc", tc, (i % 3) == 2);
      cyc(1, 0, 0, 0);
    end
    periodic = 0;
    repeat (4) cyc(1, 0, 0, 0);
    chk("per_drop_expired", running, 0);

    // pause / resume
    cyc(0, 10, 0, 0);
    cyc(1, 0, 1, 0);
    repeat (4) cyc(1, 0, 0, 0);
    chk("pause_Y6", Y, 6);
    cyc(1, 0, 0, 1);
    repeat (5) begin
      cyc(1, 0, 0, 0);
      chk("pause_hold", Y, 6);
    end
    cyc(1, 0, 1, 0);
    repeat (6) cyc(1, 0, 0, 0);
    chk("resume_tc", tc, 1);
    chk("resume_Y0", Y, 0);

    // zero reload and abort
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 0);
    chk("zero_tc", tc, 1);
    cyc(1, 0, 0, 0);
    chk("zero_tc_drop", tc, 0);
    cyc(0, 5, 0, 0);
    cyc(1, 0, 1, 0);
    repeat (2) cyc(1, 0, 0, 0);
    chk("abort_Y3", Y, 3);
    cyc(0, 9, 1, 0);
    chk("abort_Y9", Y, 9);
    chk("abort_idle", running, 0);

    // priority
    cyc(1, 0, 1, 1);
    chk("startstop_idle", running, 0);
    cyc(0, 3, 0, 0);
    cyc(1, 0, 1, 0);
    repeat (2) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    chk("stop_at1_Y", Y, 1);
    chk("stop_at1_tc", tc, 0);

    // large value
    cyc(0, 32'hFFFF_FFFF, 0, 0);
    cyc(1, 0, 1, 0);
    repeat (3) cyc(1, 0, 0, 0);

    // randomized
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) periodic = ~periodic;
      cyc(($urandom_range(0, 11) != 0),
          ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 6)),
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 11) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
